// File: rtl/kl_scan_controller_pkg.sv
// rtl/kl_scan_controller_pkg.sv - shared types and constants for the KL scan controller
// Purpose: FSM state encoding, digit-code width and the all-dark segment pattern.
// Ports: none (package).
package kl_scan_controller_pkg;

  typedef enum logic {
    STATE_IDLE = 1'b0,
    STATE_SCAN = 1'b1
  } state_t;

  localparam int          CODE_W  = 4;
  localparam int          SEG_W   = 7;
  localparam logic [6:0]  SEG_OFF = 7'b0000000;

endpackage

// File: rtl/kl_seg_decode.sv
// rtl/kl_seg_decode.sv - combinational 4-bit digit code to 7-bit KL pattern
// Purpose: maps codes 0..9 to their KL patterns; codes 10..15 decode dark.
// Ports:
//   code  in   [3:0]  digit code
//   seg   out  [6:0]  KL pattern
module kl_seg_decode
  import kl_scan_controller_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [SEG_W-1:0]  seg
);

  always_comb begin
    seg = SEG_OFF;
    unique case (code)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b1000000;
      4'd2:    seg = 7'b1000001;
      4'd3:    seg = 7'b1001001;
      4'd4:    seg = 7'b0100011;
      4'd5:    seg = 7'b0011101;
      4'd6:    seg = 7'b0100101;
      4'd7:    seg = 7'b0010011;
      4'd8:    seg = 7'b0110110;
      4'd9:    seg = 7'b0110111;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/kl_scan_controller.sv
// rtl/kl_scan_controller.sv - double-buffered time-multiplexed KL display scanner
// Purpose: accepts a packed word of digit codes, holds it in a shadow buffer,
//   swaps it into the active buffer at frame boundaries and scans the digits
//   through one shared decoder with a dead slot before each digit.
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   clear       in   synchronous abort to IDLE, drops pending data
//   load_valid  in   load_data valid
//   load_ready  out  shadow buffer free
//   load_data   in   [4*NUM_DIGITS-1:0] digit codes, digit 0 in [3:0]
//   blank_en    in   leading-zero blanking enable
//   seg         out  [6:0] registered KL pattern
//   digit_sel   out  [NUM_DIGITS-1:0] registered one-hot digit enable
//   frame_done  out  pulse on the last cycle of each frame
//   busy        out  high while scanning
module kl_scan_controller
  import kl_scan_controller_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic [CODE_W*NUM_DIGITS-1:0] load_data,
  input  logic                         blank_en,
  output logic [SEG_W-1:0]             seg,
  output logic [NUM_DIGITS-1:0]        digit_sel,
  output logic                         frame_done,
  output logic                         busy
);

  localparam int DATA_W = CODE_W * NUM_DIGITS;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SLOT_W = $clog2(SCAN_DIV);

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);

  state_t                  state_q, state_d;
  logic                    pending_q, pending_d;
  logic [DATA_W-1:0]       shadow_q, shadow_d;
  logic [DATA_W-1:0]       active_q, active_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [SLOT_W-1:0]       slot_q, slot_d;

  logic [SEG_W-1:0]        seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
  logic                    frame_done_q, frame_done_d;
  logic                    busy_q, busy_d;

  logic                    accept;
  logic                    frame_end;
  logic [CODE_W-1:0]       code_sel;
  logic [SEG_W-1:0]        seg_dec;
  logic [NUM_DIGITS-1:0]   zero_from;
  logic                    zero_run;
  logic                    blank_sel;
  logic                    lit;

  assign load_ready = !pending_q;
  assign accept     = load_valid && load_ready && !clear;
  assign frame_end  = (state_q == STATE_SCAN) && (idx_q == IDX_LAST) && (slot_q == SLOT_LAST);

  // Next-state for buffers, FSM and counters.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    idx_d     = idx_q;
    slot_d    = slot_q;

    if (accept) begin
      shadow_d  = load_data;
      pending_d = 1'b1;
    end

    unique case (state_q)
      STATE_IDLE: begin
        if (pending_q) begin
          active_d  = shadow_q;
          pending_d = 1'b0;
          state_d   = STATE_SCAN;
          idx_d     = '0;
          slot_d    = '0;
        end
      end
      STATE_SCAN: begin
        if (slot_q == SLOT_LAST) begin
          slot_d = '0;
          idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
          slot_d = slot_q + 1'b1;
        end
        // A pending word can never coincide with an accept here, since
        // load_ready is low whenever pending_q is set.
        if (frame_end && pending_q) begin
          active_d  = shadow_q;
          pending_d = 1'b0;
        end
      end
      default: state_d = STATE_IDLE;
    endcase

    if (clear) begin
      state_d   = STATE_IDLE;
      pending_d = 1'b0;
      idx_d     = '0;
      slot_d    = '0;
    end
  end

  // zero_from[i]: digits i..NUM_DIGITS-1 of the buffer being shown are all zero.
  always_comb begin
    zero_run  = 1'b1;
    zero_from = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run && (active_d[i*CODE_W +: CODE_W] == '0);
      zero_from[i] = zero_run;
    end
  end

  // Digit mux feeding the shared decoder. Outputs are computed from the
  // next-state values so the registered outputs line up with the counters
  // they describe.
  always_comb begin
    code_sel    = '0;
    blank_sel   = 1'b0;
    digit_sel_d = '0;
    lit         = (state_d == STATE_SCAN) && (slot_d != '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        code_sel       = active_d[i*CODE_W +: CODE_W];
        blank_sel      = blank_en && (i != 0) && zero_from[i];
        digit_sel_d[i] = lit;
      end
    end
  end

  kl_seg_decode u_seg_decode (
    .code (code_sel),
    .seg  (seg_dec)
  );

  always_comb begin
    seg_d        = (lit && !blank_sel) ? seg_dec : SEG_OFF;
    frame_done_d = (state_d == STATE_SCAN) && (idx_d == IDX_LAST) && (slot_d == SLOT_LAST);
    busy_d       = (state_d == STATE_SCAN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= STATE_IDLE;
      pending_q    <= 1'b0;
      shadow_q     <= '1;
      active_q     <= '1;
      idx_q        <= '0;
      slot_q       <= '0;
      seg_q        <= SEG_OFF;
      digit_sel_q  <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      idx_q        <= idx_d;
      slot_q       <= slot_d;
      seg_q        <= seg_d;
      digit_sel_q  <= digit_sel_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign seg        = seg_q;
  assign digit_sel  = digit_sel_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_kl_scan_controller.sv
// tb/tb_kl_scan_controller.sv - directed self-checking bench for kl_scan_controller
module tb_kl_scan_controller;

  localparam int ND = 4;
  localparam int SD = 4;

  localparam logic [6:0] K0   = 7'b1111110;
  localparam logic [6:0] K1   = 7'b1000000;
  localparam logic [6:0] K3   = 7'b1001001;
  localparam logic [6:0] K5   = 7'b0011101;
  localparam logic [6:0] K9   = 7'b0110111;
  localparam logic [6:0] DARK = 7'b0000000;

  // {seg, digit_sel, busy, load_ready, frame_done} while idle
  localparam logic [13:0] IDLE_VEC = 14'b0000000_0000_0_1_0;

  logic            clk;
  logic            rst_n;
  logic            clear;
  logic            load_valid;
  logic            load_ready;
  logic [4*ND-1:0] load_data;
  logic            blank_en;
  logic [6:0]      seg;
  logic [ND-1:0]   digit_sel;
  logic            frame_done;
  logic            busy;

  int checks   = 0;
  int failures = 0;

  kl_scan_controller #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .blank_en   (blank_en),
    .seg        (seg),
    .digit_sel  (digit_sel),
    .frame_done (frame_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] out_vec();
    return {seg, digit_sel, busy, load_ready, frame_done};
  endfunction

  // Steps through one full frame from slot 0 of digit 0; optionally offers a
  // load while sitting at frame position load_at.
  task automatic run_frame(input string name, input logic [6:0] s3, input logic [6:0] s2,
                           input logic [6:0] s1, input logic [6:0] s0,
                           input int load_at, input logic [15:0] load_word);
    logic [6:0] segs [4];
    int         idx;
    int         slot;
    segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
    for (int p = 0; p < ND*SD; p++) begin
      step();
      load_valid = 1'b0;
      idx  = p / SD;
      slot = p % SD;
      check({name, "_sel"},   32'(digit_sel),  (slot == 0) ? 32'd0 : (32'd1 << idx));
      check({name, "_seg"},   32'(seg),        (slot == 0) ? 32'd0 : 32'(segs[idx]));
      check({name, "_fdone"}, 32'(frame_done), (p == ND*SD-1) ? 32'd1 : 32'd0);
      check({name, "_busy"},  32'(busy),       32'd1);
      check({name, "_ready"}, 32'(load_ready), (load_at >= 0 && p > load_at) ? 32'd0 : 32'd1);
      if (p == load_at) begin
        load_valid = 1'b1;
        load_data  = load_word;
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    clear      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    blank_en   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_vec", 32'(out_vec()), 32'(IDLE_VEC));
    rst_n = 1'b1;

    // idle without any load
    for (int i = 0; i < 100; i++) begin
      step();
      check("idle_vec", 32'(out_vec()), 32'(IDLE_VEC));
    end

    // load 9310 from IDLE: cycle A accepts
    load_valid = 1'b1;
    load_data  = 16'h9310;
    step();
    load_valid = 1'b0;
    check("acc_ready", 32'(load_ready), 32'd0);
    check("acc_busy",  32'(busy),       32'd0);
    run_frame("f1_9310", K9, K3, K1, K0, -1, 16'h0);
    // current frame still 9310 while 0005 waits in the shadow buffer
    run_frame("f2_9310", K9, K3, K1, K0, 2, 16'h0005);
    run_frame("f3_0005", K0, K0, K0, K5, -1, 16'h0);

    // leading-zero blanking
    blank_en = 1'b1;
    run_frame("f4_blank5", DARK, DARK, DARK, K5, 5, 16'h0000);
    run_frame("f5_blank0", DARK, DARK, DARK, K0, 5, 16'hFA00);
    blank_en = 1'b0;
    run_frame("f6_fa00", DARK, DARK, K0, K0, -1, 16'h0);

    // clear mid-frame with a pending word
    repeat (3) step();
    load_valid = 1'b1;
    load_data  = 16'h1111;
    step();
    load_valid = 1'b0;
    check("clr_pend_ready", 32'(load_ready), 32'd0);
    repeat (3) step();
    check("pre_clr_sel", 32'(digit_sel), 32'b0010);
    check("pre_clr_seg", 32'(seg),       32'(K0));
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_vec", 32'(out_vec()), 32'(IDLE_VEC));
    for (int i = 0; i < 10; i++) begin
      step();
      check("post_clr_vec", 32'(out_vec()), 32'(IDLE_VEC));
    end

    // asynchronous reset during slot 2 of digit 1
    load_valid = 1'b1;
    load_data  = 16'h9310;
    step();
    load_valid = 1'b0;
    repeat (7) step();
    check("pre_rst_sel", 32'(digit_sel), 32'b0010);
    check("pre_rst_seg", 32'(seg),       32'(K1));
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_vec", 32'(out_vec()), 32'(IDLE_VEC));
    repeat (2) step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("post_rst_vec", 32'(out_vec()), 32'(IDLE_VEC));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
